lr_expand: RTL and testbench

- Reader side of the compressed check-to-variable message format produced by the check node cells.
- Accepts one compressed lr word per row over a valid/ready handshake. Holds it and serialises the six signed check-to-variable messages, one edge per cycle, toward the variable-node/LLR update path.
- Decodes the fields: least magnitude, second-least magnitude, least location, sign XOR, and six per-edge signs.

---
 rtl/ldpc_pkg.sv | 29 ++
 rtl/lr_edge_sel.sv | 42 ++++
 rtl/lr_expand.sv | 90 +++++++++
 tb/tb_lr_expand.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared constants and field layout of the compressed check-to-variable (lr) word.
// The same layout is used by the check node cells that produce it.
package ldpc_pkg;

  localparam int unsigned D_WID_DEFAULT = 8;
  localparam int unsigned NUM_EDGE      = 6;
  localparam int unsigned LOC_WID       = 3;

  // Fixed low fields: sign k sits at bit SIGN_BASE-k, so sign5 is bit 0.
  localparam int unsigned SIGN_BASE = 5;
  localparam int unsigned SXOR_BIT  = 6;
  localparam int unsigned LOC_MSB   = 9;

  function automatic int unsigned lr_wid(input int unsigned d_wid);
    return 2 * d_wid + 10;
  endfunction

  function automatic int unsigned abs_less_msb(input int unsigned d_wid);
    return d_wid + 9;
  endfunction

  function automatic int unsigned abs_least_msb(input int unsigned d_wid);
    return 2 * d_wid + 9;
  endfunction

  localparam int unsigned ABS_LESS_MSB  = abs_less_msb(D_WID_DEFAULT);
  localparam int unsigned ABS_LEAST_MSB = abs_least_msb(D_WID_DEFAULT);

endpackage

// File: rtl/lr_edge_sel.sv
// Decodes one edge of a compressed lr word into a signed two's-complement message.
module lr_edge_sel
  import ldpc_pkg::*;
#(
  parameter  int unsigned D_WID  = D_WID_DEFAULT,
  localparam int unsigned LR_WID = 2 * D_WID + 10
) (
  input  logic [LR_WID-1:0] lr,
  input  logic [2:0]        idx,
  output logic [D_WID-1:0]  msg
);

  localparam int unsigned LeastMsb = abs_least_msb(D_WID);
  localparam int unsigned LessMsb  = abs_less_msb(D_WID);

  logic [D_WID-1:0] abs_least;
  logic [D_WID-1:0] abs_less;
  logic [2:0]       least_loc;
  logic [D_WID-1:0] mag_raw;
  logic [D_WID-1:0] mag;
  logic [7:0]       sign_by_edge;
  logic             neg;

  assign abs_least = lr[LeastMsb -: D_WID];
  assign abs_less  = lr[LessMsb -: D_WID];
  assign least_loc = lr[LOC_MSB -: LOC_WID];

  always_comb begin
    sign_by_edge = '0;
    for (int k = 0; k < NUM_EDGE; k++) begin
      sign_by_edge[k] = lr[SIGN_BASE-k];
    end
  end

  // The least-magnitude edge itself sees the second-least magnitude.
  assign mag_raw = (idx == least_loc) ? abs_less : abs_least;
  // Clipping to the positive maximum keeps the negation from wrapping.
  assign mag     = mag_raw[D_WID-1] ? {1'b0, {(D_WID-1){1'b1}}} : mag_raw;
  assign neg     = sign_by_edge[idx] ^ lr[SXOR_BIT];
  assign msg     = neg ? (~mag + 1'b1) : mag;

endmodule

// File: rtl/lr_expand.sv
// Holds one compressed lr word and serialises its six edge messages, one per cycle,
// over a valid/ready handshake.
module lr_expand
  import ldpc_pkg::*;
#(
  parameter  int unsigned D_WID  = D_WID_DEFAULT,
  localparam int unsigned LR_WID = 2 * D_WID + 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LR_WID-1:0] lr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [D_WID-1:0]  out_lr,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              loc_err
);

  localparam logic [2:0] LastIdx = 3'(NUM_EDGE - 1);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [LR_WID-1:0] hold_q, hold_d;
  logic              loc_err_q, loc_err_d;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q == StEmit);
  assign out_idx   = cnt_q;
  assign out_last  = (cnt_q == LastIdx);
  assign loc_err   = loc_err_q;

  // out_ready -> in_ready is combinational so a new row loads with no bubble.
  assign in_ready = !flush && ((state_q == StIdle) || (out_last && out_ready));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    loc_err_d = 1'b0;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      hold_d  = '0;
    end else if (in_fire) begin
      state_d   = StEmit;
      cnt_d     = '0;
      hold_d    = lr_in;
      loc_err_d = (lr_in[LOC_MSB -: LOC_WID] > LastIdx);
    end else if (out_fire) begin
      if (out_last) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hold_q    <= '0;
      loc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      loc_err_q <= loc_err_d;
    end
  end

  lr_edge_sel #(
    .D_WID (D_WID)
  ) u_edge_sel (
    .lr  (hold_q),
    .idx (cnt_q),
    .msg (out_lr)
  );

endmodule

// File: tb/tb_lr_expand.sv
// Directed bench for lr_expand: expansion, back-to-back rows, stall, clip, flush, reset.
module tb_lr_expand;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 2 * DW + 10;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] lr_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_lr;
  logic [2:0]    out_idx;
  logic          out_last;
  logic          loc_err;

  int tests;
  int fails;

  lr_expand #(
    .D_WID (DW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lr_in     (lr_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lr    (out_lr),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .loc_err   (loc_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Signs are given sign0..sign5 from left to right, matching the word layout.
  function automatic logic [LW-1:0] mk_word(input logic [7:0] least, input logic [7:0] less,
                                            input logic [2:0] loc, input logic sxor,
                                            input logic [5:0] signs);
    return {least, less, loc, sxor, signs};
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks a full row from idx 0 with out_ready held high; e packs edge0 in the MSBs.
  task automatic check_row(input string name, input logic [47:0] e, input logic lerr);
    logic [7:0] ev;
    for (int k = 0; k < 6; k++) begin
      ev = e[47-8*k -: 8];
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_idx"}, 32'(out_idx), 32'(k));
      check({name, "_lr"}, 32'(out_lr), 32'(ev));
      check({name, "_last"}, 32'(out_last), 32'(k == 5));
      check({name, "_locerr"}, 32'(loc_err), 32'(lerr && (k == 0)));
      tick();
    end
    check({name, "_end_valid"}, 32'(out_valid), 32'd0);
  endtask

  logic [LW-1:0] w1, w2, w3;
  logic [47:0]   e1, e2, e3;

  initial begin
    tests     = 0;
    fails     = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    lr_in     = '0;

    w1 = mk_word(8'd5, 8'd9, 3'd2, 1'b1, 6'b010011);
    e1 = {8'hFB, 8'h05, 8'hF7, 8'hFB, 8'h05, 8'h05};
    w2 = mk_word(8'd3, 8'h20, 3'd0, 1'b0, 6'b100000);
    e2 = {8'hE0, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
    w3 = mk_word(8'h80, 8'h10, 3'd7, 1'b0, 6'b111111);
    e3 = {6{8'h81}};

    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_lr", 32'(out_lr), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_locerr", 32'(loc_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #8 reset_n = 1'b1;
    tick();

    // Basic expansion
    in_valid  = 1'b1;
    lr_in     = w1;
    out_ready = 1'b1;
    #1 check("basic_in_ready", 32'(in_ready), 32'd1);
    check("basic_pre_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check_row("basic", e1, 1'b0);
    check("basic_idle_ready", 32'(in_ready), 32'd1);

    // Back-to-back: second word offered throughout the first row
    in_valid = 1'b1;
    lr_in    = w1;
    tick();
    lr_in = w2;
    for (int k = 0; k < 6; k++) begin
      check("b2b_a_valid", 32'(out_valid), 32'd1);
      check("b2b_a_idx", 32'(out_idx), 32'(k));
      check("b2b_a_lr", 32'(out_lr), 32'(e1[47-8*k -: 8]));
      check("b2b_a_in_ready", 32'(in_ready), 32'(k == 5));
      tick();
    end
    in_valid = 1'b0;
    check_row("b2b_b", e2, 1'b0);

    // Backpressure at idx 2 while another word is offered
    in_valid = 1'b1;
    lr_in    = w1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    lr_in     = w3;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_idx", 32'(out_idx), 32'd2);
      check("stall_lr", 32'(out_lr), 32'hF7);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 2; k < 6; k++) begin
      check("resume_idx", 32'(out_idx), 32'(k));
      check("resume_lr", 32'(out_lr), 32'(e1[47-8*k -: 8]));
      tick();
    end
    check("resume_end_valid", 32'(out_valid), 32'd0);

    // Clip and out-of-range least location
    in_valid = 1'b1;
    lr_in    = w3;
    tick();
    in_valid = 1'b0;
    check_row("clip", e3, 1'b1);

    // Flush at idx 3 with a word offered in the same cycle
    in_valid = 1'b1;
    lr_in    = w1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("flush_pre_idx", 32'(out_idx), 32'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    lr_in    = w2;
    #1 check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_idx", 32'(out_idx), 32'd0);
    check("flush_in_ready_after", 32'(in_ready), 32'd1);
    tick();
    check("flush_dropped", 32'(out_valid), 32'd0);

    // Reset mid-row, then a fresh word
    in_valid = 1'b1;
    lr_in    = w2;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("prerst_idx", 32'(out_idx), 32'd2);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_lr", 32'(out_lr), 32'd0);
    check("midrst_idx", 32'(out_idx), 32'd0);
    check("midrst_last", 32'(out_last), 32'd0);
    #1 reset_n = 1'b1;
    tick();
    in_valid = 1'b1;
    lr_in    = w1;
    tick();
    in_valid = 1'b0;
    check_row("postrst", e1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
